lbist_ctrl: RTL

LBIST sequencer that drives the pseudo-random pattern LFSR, the scan chain and the response MISR through a complete self-test run, then compares the final signature against a golden value. It sits between the test-mode host (start/abort/done/pass) and the LBIST datapath (LFSR, scan chain, MISR). It owns only sequencing and comparison; pattern generation and compaction live in their own blocks.

---
 rtl/lbist_pkg.sv | 35 +++
 rtl/lbist_tc_counter.sv | 31 +++
 rtl/lbist_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lbist_pkg.sv
// Shared LBIST types: FSM states, datapath strobe bundle and counter-width helpers.
package lbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // Control strobes toward LFSR, scan chain and MISR; shared with multi-chain variants.
  typedef struct packed {
    logic lfsr_rst;
    logic lfsr_en;
    logic scan_en;
    logic capture;
    logic misr_rst;
    logic misr_en;
  } strobe_t;

  // Bits needed to hold n_vals distinct values, never less than one.
  function automatic int cnt_w(input int n_vals);
    return (n_vals > 2) ? $clog2(n_vals) : 1;
  endfunction

  localparam int CHAIN_LEN_DFLT  = 32;
  localparam int N_PATTERNS_DFLT = 1000;
  localparam int SIG_W_DFLT      = 17;
  localparam int SHIFT_W_DFLT    = cnt_w(CHAIN_LEN_DFLT);
  localparam int PAT_W_DFLT      = cnt_w(N_PATTERNS_DFLT + 1);

endpackage

// File: rtl/lbist_tc_counter.sv
// Up-counter with clear/enable and a terminal-count flag at TC_VAL.
// At MAX it either wraps to zero (WRAP=1) or saturates (WRAP=0).
module lbist_tc_counter #(
  parameter int W      = 4,
  parameter int TC_VAL = 0,
  parameter int MAX    = 1,
  parameter bit WRAP   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(TC_VAL));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == W'(MAX)) begin
        cnt <= WRAP ? '0 : cnt;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/lbist_ctrl.sv
// LBIST run sequencer: INIT, N_PATTERNS x (shift + capture), unload, signature compare.
// Outputs are Moore-decoded from the state register and counters.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int               CHAIN_LEN  = CHAIN_LEN_DFLT,
  parameter int               N_PATTERNS = N_PATTERNS_DFLT,
  parameter int               SIG_W      = SIG_W_DFLT,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [SIG_W-1:0]                  misr_sig,
  output logic                              lfsr_rst,
  output logic                              lfsr_en,
  output logic                              scan_en,
  output logic                              capture,
  output logic                              misr_rst,
  output logic                              misr_en,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [cnt_w(N_PATTERNS+1)-1:0]    pat_cnt
);

  localparam int SHIFT_W = cnt_w(CHAIN_LEN);
  localparam int PAT_W   = cnt_w(N_PATTERNS + 1);

  state_t              state, next_state;
  strobe_t             strb;
  logic [SHIFT_W-1:0]  shift_cnt;
  logic                shift_last;
  logic                pat_last;
  logic                start_ok;
  logic                abort_run;

  assign start_ok  = (state == ST_IDLE) && start && !abort;
  assign abort_run = abort && (state != ST_IDLE) && (state != ST_DONE);

  lbist_tc_counter #(
    .W(SHIFT_W), .TC_VAL(CHAIN_LEN - 1), .MAX(CHAIN_LEN - 1), .WRAP(1'b1)
  ) u_shift_cnt (
    .clk(clk), .reset(reset), .clear(state == ST_IDLE),
    .en((state == ST_SHIFT) || (state == ST_UNLOAD)),
    .cnt(shift_cnt), .tc(shift_last)
  );

  // pat_last flags the capture that will complete the final pattern.
  lbist_tc_counter #(
    .W(PAT_W), .TC_VAL(N_PATTERNS - 1), .MAX(N_PATTERNS), .WRAP(1'b0)
  ) u_pat_cnt (
    .clk(clk), .reset(reset), .clear(start_ok),
    .en((state == ST_CAPTURE) && !abort),
    .cnt(pat_cnt), .tc(pat_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (start_ok) next_state = ST_INIT;
      ST_INIT:    next_state = ST_SHIFT;
      ST_SHIFT:   if (shift_last) next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = pat_last ? ST_UNLOAD : ST_SHIFT;
      ST_UNLOAD:  if (shift_last) next_state = ST_COMPARE;
      ST_COMPARE: next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    if (abort_run) next_state = ST_IDLE;
  end

  // The first pattern shifts out unknown chain contents, so it is kept out of the MISR.
  always_comb begin
    strb = '0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_INIT:    begin strb.lfsr_rst = 1'b1; strb.misr_rst = 1'b1; busy = 1'b1; end
      ST_SHIFT:   begin
        strb.scan_en = 1'b1; strb.lfsr_en = 1'b1;
        strb.misr_en = (pat_cnt != '0); busy = 1'b1;
      end
      ST_CAPTURE: begin strb.capture = 1'b1; busy = 1'b1; end
      ST_UNLOAD:  begin
        strb.scan_en = 1'b1; strb.lfsr_en = 1'b1; strb.misr_en = 1'b1; busy = 1'b1;
      end
      ST_COMPARE: busy = 1'b1;
      ST_DONE:    done = 1'b1;
      default:    ;
    endcase
  end

  assign lfsr_rst = strb.lfsr_rst;
  assign lfsr_en  = strb.lfsr_en;
  assign scan_en  = strb.scan_en;
  assign capture  = strb.capture;
  assign misr_rst = strb.misr_rst;
  assign misr_en  = strb.misr_en;

  always_ff @(posedge clk) begin
    if (reset || start_ok || abort_run) begin
      pass <= 1'b0;
    end else if (state == ST_COMPARE) begin
      pass <= (misr_sig == GOLDEN_SIG);
    end
  end

  // Every run must begin shifting from bit 0 of the chain.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_INIT) assert (shift_cnt == '0);
  end

endmodule
